// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_pkg
// Shared widths, data-memory latency and memory request/response types.
// Rev     : 1.0
// ============================================================================
package cpu_pkg;

    localparam int WORD_W       = 16;
    localparam int ADDR_W       = 16;
    localparam int DMEM_LATENCY = 4;

    typedef struct packed {
        logic              enable;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } mem_rsp_t;

endpackage
`default_nettype wire

// File: rtl/lat_pipe.sv
`default_nettype none
// ============================================================================
// Module : lat_pipe
// LATENCY-deep shift register of read responses with synchronous clear.
// Rev    : 1.0
// ============================================================================
module lat_pipe #(
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             clr_i,
    input  cpu_pkg::mem_rsp_t in_i,
    output cpu_pkg::mem_rsp_t out_o
);
    import cpu_pkg::*;

    mem_rsp_t stage_q [LATENCY];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_o = stage_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/dmem_latency_resp.sv
`default_nettype none
// ============================================================================
// Module : dmem_latency_resp
// Pipelined data memory: same-edge writes, fixed-latency reads with echo.
// Rev    : 1.0
// ============================================================================
module dmem_latency_resp #(
    parameter int LATENCY   = cpu_pkg::DMEM_LATENCY,
    parameter int ADDR_W    = cpu_pkg::ADDR_W,
    parameter int DATA_W    = cpu_pkg::WORD_W,
    parameter int MEM_WORDS = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              data_valid_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [3:0]        pending_o
);
    import cpu_pkg::*;

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    mem_req_t          req;
    mem_rsp_t          rsp_in;
    mem_rsp_t          rsp_out;
    logic [ADDR_W-1:0] addr_even;
    logic [IDX_W-1:0]  word_idx;
    logic              issue;
    logic              retire;
    logic              clr;
    logic [3:0]        pending_q;
    logic [3:0]        pending_d;
    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    assign req       = '{enable: enable_i, wr: wr_i, addr: addr_i, data: data_in_i};
    assign addr_even = req.addr & ~ADDR_W'(1);
    assign word_idx  = IDX_W'(32'(addr_even[ADDR_W-1:1]) % MEM_WORDS);

    // Requests seen during reset are dropped, including writes.
    always_ff @(posedge clk) begin
        if (rst_n && req.enable && req.wr) begin
            mem_q[word_idx] <= req.data;
        end
    end

    assign issue  = rst_n & req.enable & ~req.wr;
    assign rsp_in = '{valid: issue, addr: addr_even, data: mem_q[word_idx]};
    assign clr    = ~rst_n;

    lat_pipe #(
        .LATENCY (LATENCY)
    ) u_lat_pipe (
        .clk   (clk),
        .clr_i (clr),
        .in_i  (rsp_in),
        .out_o (rsp_out)
    );

    assign retire    = rsp_out.valid;
    assign pending_d = pending_q + {3'b000, issue} - {3'b000, retire};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o    = pending_q;
    assign data_valid_o = rsp_out.valid;
    assign data_out_o   = rsp_out.valid ? rsp_out.data : '0;
    assign data_addr_o  = rsp_out.valid ? rsp_out.addr : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_latency_resp.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_latency_resp
// Scoreboard bench for the fixed-latency data-memory responder.
// Rev    : 1.0
// ============================================================================
module tb_dmem_latency_resp;

    localparam int L = 4;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic        wr     = 1'b0;
    logic [15:0] addr   = '0;
    logic [15:0] din    = '0;
    logic [15:0] dout;
    logic        dvalid;
    logic [15:0] daddr;
    logic [3:0]  pend;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int          due;
        logic [15:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    dmem_latency_resp #(
        .LATENCY   (L),
        .ADDR_W    (16),
        .DATA_W    (16),
        .MEM_WORDS (65536)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .wr_i         (wr),
        .addr_i       (addr),
        .data_in_i    (din),
        .data_out_o   (dout),
        .data_valid_o (dvalid),
        .data_addr_o  (daddr),
        .pending_o    (pend)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every response must match the oldest outstanding read on its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (pend !== 4'(sb.size())) begin
                n_fail++;
                $display("FAIL pending cyc=%0d got=%0d exp=%0d", cyc, pend, sb.size());
            end
            if (dvalid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp cyc=%0d addr=%h data=%h exp=none", cyc, daddr, dout);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.due != cyc || daddr !== mon_e.a || dout !== mon_e.d) begin
                        n_fail++;
                        $display("FAIL rsp cyc=%0d got addr=%h data=%h exp cyc=%0d addr=%h data=%h",
                                 cyc, daddr, dout, mon_e.due, mon_e.a, mon_e.d);
                    end
                end
            end else begin
                n_checks++;
                if (dvalid !== 1'b0 || dout !== 16'h0 || daddr !== 16'h0) begin
                    n_fail++;
                    $display("FAIL idle_outputs cyc=%0d got v=%b data=%h addr=%h exp 0/0/0",
                             cyc, dvalid, dout, daddr);
                end
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL missed_rsp cyc=%0d got none exp addr=%h data=%h due=%0d",
                             cyc, sb[0].a, sb[0].d, sb[0].due);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        enable = 1'b1;
        wr     = 1'b1;
        addr   = a;
        din    = d;
        @(posedge clk);
        #1;
        enable = 1'b0;
        wr     = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] exp_d);
        exp_t e;
        enable = 1'b1;
        wr     = 1'b0;
        addr   = a;
        @(posedge clk);
        #1;
        enable = 1'b0;
        e.due  = cyc + L - 1;
        e.a    = a & 16'hFFFE;
        e.d    = exp_d;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        enable = 1'b1;
        wr     = 1'b0;
        addr   = 16'h0020;
        step(3);
        n_checks++;
        if (dvalid !== 1'b0 || dout !== 16'h0 || daddr !== 16'h0 || pend !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b data=%h addr=%h pend=%0d exp 0/0/0/0",
                     dvalid, dout, daddr, pend);
        end
        enable = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(1);
    endtask

    task automatic test_single_read;
        do_write(16'h0020, 16'hBEEF);
        step(1);
        do_read(16'h0020, 16'hBEEF);
        for (int k = 0; k < L; k++) begin
            if (k > 0) step(1);
            n_checks++;
            if (pend !== 4'd1 || dvalid !== (k == L - 1)) begin
                n_fail++;
                $display("FAIL single_timing k=%0d got pend=%0d v=%b exp pend=1 v=%b",
                         k, pend, dvalid, (k == L - 1));
            end
        end
        step(1);
        n_checks++;
        if (pend !== 4'd0 || dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_retire got pend=%0d v=%b exp pend=0 v=0", pend, dvalid);
        end
        step(1);
    endtask

    task automatic test_burst;
        int peak;
        for (int i = 0; i < 4; i++) do_write(16'h0040 + 16'(2 * i), 16'h1111 * 16'(i + 1));
        peak = 0;
        for (int i = 0; i < 4; i++) begin
            do_read(16'h0040 + 16'(2 * i), 16'h1111 * 16'(i + 1));
            if (int'(pend) > peak) peak = int'(pend);
        end
        for (int i = 0; i < L + 1; i++) begin
            step(1);
            if (int'(pend) > peak) peak = int'(pend);
        end
        n_checks++;
        if (peak != 4) begin
            n_fail++;
            $display("FAIL burst_peak got=%0d exp=4", peak);
        end
    endtask

    task automatic test_raw_wr;
        do_write(16'h00A0, 16'h5A5A);
        do_read(16'h00A0, 16'h5A5A);
        do_write(16'h00A0, 16'h0000);
        step(L + 1);
        do_read(16'h00A0, 16'h0000);
        step(L + 1);
    endtask

    task automatic test_reset_mid;
        do_read(16'h0040, 16'h1111);
        do_read(16'h0042, 16'h2222);
        do_read(16'h0044, 16'h3333);
        rst_n  = 1'b0;
        enable = 1'b1;
        wr     = 1'b1;
        addr   = 16'h0040;
        din    = 16'hDEAD;
        @(posedge clk);
        #1;
        sb.delete();
        rst_n  = 1'b1;
        enable = 1'b0;
        wr     = 1'b0;
        n_checks++;
        if (pend !== 4'd0 || dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear got pend=%0d v=%b exp pend=0 v=0", pend, dvalid);
        end
        for (int i = 0; i < L + 2; i++) begin
            step(1);
            n_checks++;
            if (dvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_drop i=%0d got v=%b exp v=0", i, dvalid);
            end
        end
        do_read(16'h0040, 16'h1111);
        do_read(16'h0044, 16'h3333);
        step(L + 1);
    endtask

    task automatic test_odd_wrap;
        do_read(16'h0021, 16'hBEEF);
        do_write(16'hFFFE, 16'h7E57);
        do_read(16'hFFFF, 16'h7E57);
        step(L + 1);
    endtask

    task automatic test_idle;
        enable = 1'b0;
        wr     = 1'b1;
        addr   = 16'h0020;
        for (int i = 0; i < 10; i++) begin
            din = 16'($urandom);
            step(1);
            n_checks++;
            if (dvalid !== 1'b0 || dout !== 16'h0 || pend !== 4'd0) begin
                n_fail++;
                $display("FAIL idle i=%0d got v=%b data=%h pend=%0d exp 0/0/0", i, dvalid, dout, pend);
            end
        end
        wr = 1'b0;
        do_read(16'h0020, 16'hBEEF);
        step(L + 1);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst();
        test_raw_wr();
        test_reset_mid();
        test_odd_wrap();
        test_idle();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected got=%0d exp=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
